// File: rtl/ch_way_arbiter_pkg.sv
// Shared types and defaults for the NAND channel way arbiter.
package ch_way_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int          GAP_CYC_DEF    = 2;
  localparam logic [15:0] TENURE_MAX_DEF = 16'hFFFF;
  localparam int          TEN_W          = 16;
  localparam int          GAP_W          = 4;

endpackage

// File: rtl/ch_way_arbiter_if.sv
// Request/grant bundle between the NAND ways (master) and the channel arbiter (slave).
interface ch_way_arbiter_if #(
  parameter int NUM_WAY = 4
);
  localparam int IDX_W = $clog2(NUM_WAY);

  logic [NUM_WAY-1:0] i_ch_req;
  logic               i_ovf_clr;
  logic [NUM_WAY-1:0] o_ch_gnt;
  logic [IDX_W-1:0]   o_gnt_idx;
  logic               o_gnt_vld;
  logic               o_ch_busy;
  logic               o_tenure_ovf;
  logic [IDX_W-1:0]   o_ovf_way;

  modport master (
    output i_ch_req, i_ovf_clr,
    input  o_ch_gnt, o_gnt_idx, o_gnt_vld, o_ch_busy, o_tenure_ovf, o_ovf_way
  );

  modport slave (
    input  i_ch_req, i_ovf_clr,
    output o_ch_gnt, o_gnt_idx, o_gnt_vld, o_ch_busy, o_tenure_ovf, o_ovf_way
  );
endinterface

// File: rtl/ch_way_arbiter_rr_sel.sv
// Round-robin pick: first requester after last_owner, with wrap. Purely combinational.
module ch_way_arbiter_rr_sel #(
  parameter int NUM_WAY = 4,
  parameter int IDX_W   = $clog2(NUM_WAY)
) (
  input  logic [NUM_WAY-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [IDX_W-1:0]   sel_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  // Walk farthest-to-nearest so the nearest requester overwrites and wins.
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = NUM_WAY; k >= 1; k--) begin
      idx = IDX_W'((int'(last_owner_i) + k) % NUM_WAY);
      if (req_i[idx]) begin
        sel_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ch_way_arbiter.sv
// Non-preemptive round-robin owner of one NAND channel; grant 1 cycle after an IDLE request.
// Owner keeps the grant until it drops its request, then GAP_CYC turnaround cycles follow.
module ch_way_arbiter
  import ch_way_arbiter_pkg::*;
#(
  parameter int          NUM_WAY    = 4,
  parameter int          GAP_CYC    = GAP_CYC_DEF,
  parameter logic [15:0] TENURE_MAX = TENURE_MAX_DEF
) (
  input logic             i_nc_clk,
  input logic             i_nc_rst,
  ch_way_arbiter_if.slave arb
);

  localparam int IDX_W = $clog2(NUM_WAY);

  arb_state_t         state_q, state_d;
  logic [NUM_WAY-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [TEN_W-1:0]   ten_q, ten_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ovf_q;
  logic [IDX_W-1:0]   ovf_way_q;
  logic               ovf_set;
  logic [IDX_W-1:0]   sel;
  logic               any_req;

  ch_way_arbiter_rr_sel #(
    .NUM_WAY (NUM_WAY),
    .IDX_W   (IDX_W)
  ) u_rr_sel (
    .req_i        (arb.i_ch_req),
    .last_owner_i (owner_q),
    .sel_o        (sel),
    .any_o        (any_req)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ten_d   = ten_q;
    gap_d   = gap_q;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_GRANT;
          gnt_d        = '0;
          gnt_d[sel]   = 1'b1;
          owner_d      = sel;
          ten_d        = '0;
        end
      end
      ST_GRANT: begin
        if (arb.i_ch_req[owner_q]) begin
          if (ten_q != TENURE_MAX) ten_d = ten_q + 16'd1;
          ovf_set = (ten_q == TENURE_MAX - 16'd1);
        end else begin
          gnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_nc_clk) begin
    if (i_nc_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= IDX_W'(NUM_WAY - 1);
      ten_q     <= '0;
      gap_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_way_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ten_q   <= ten_d;
      gap_q   <= gap_d;
      // A new overflow outranks a clear arriving in the same cycle.
      if (ovf_set) begin
        ovf_q     <= 1'b1;
        ovf_way_q <= owner_q;
      end else if (arb.i_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign arb.o_ch_gnt     = gnt_q;
  assign arb.o_gnt_idx    = owner_q;
  assign arb.o_gnt_vld    = (state_q == ST_GRANT);
  assign arb.o_ch_busy    = (state_q != ST_IDLE);
  assign arb.o_tenure_ovf = ovf_q;
  assign arb.o_ovf_way    = ovf_way_q;

endmodule
